// File: rtl/otp_pkg.sv
// Shared definitions for the OTP PROM simulation model:
// FSM state codes, data width and word-index width helper.
package otp_pkg;

    localparam int DW = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_PROG   = 2'd2;
    localparam logic [1:0] ST_VERIFY = 2'd3;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/otp_cell_array.sv
// Behavioural one-time-programmable word array: bits only ever go 0->1.
// Power-up contents are all zero and are untouched by reset.
module otp_cell_array
    import otp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    input  logic          pgm,
    input  logic [DW-1:0] din
);

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    // A read issued on the programming edge returns the new word,
    // which is what lets a verify pass observe the pulse result.
    always_ff @(posedge clk) begin
        if (pgm) begin
            mem[addr] <= mem[addr] | din;
        end
        if (ce) begin
            dout <= pgm ? (mem[addr] | din) : mem[addr];
        end
    end

endmodule

// File: rtl/otp_top.sv
// OTP PROM controller: RAM-style host port sequenced onto the cell array.
// Optional program-verify pass enabled by defining OTP_PGM_VERIFY_EN.
module otp_top
    import otp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int T_RD  = 4,
    parameter int T_PGM = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          m_ram_ren,
    input  logic [31:0]   m_ram_raddr,
    input  logic          m_ram_wen,
    input  logic [31:0]   m_ram_waddr,
    input  logic [31:0]   m_ram_wdata,
    output logic [31:0]   m_ram_rdata,
    output logic          m_ram_rvalid,
    output logic          m_ram_wdone,
    output logic          m_ram_wfail,
    output logic          m_ram_busy
);

    localparam int AW   = idx_width(DEPTH);
    localparam int CMAX = (T_RD > T_PGM) ? T_RD : T_PGM;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] RD_LAST = CW'(T_RD - 1);
    localparam logic [CW-1:0] RD_PRE  = CW'((T_RD > 1) ? T_RD - 2 : 0);
    localparam logic [CW-1:0] PG_LAST = CW'(T_PGM - 1);

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return (a >> (AW + 2)) != 32'd0;
    endfunction

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] lat_idx;
    logic          lat_oor;
    logic [DW-1:0] lat_data;

    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_dout;
    logic          rd_issue;
    logic          vf_issue;
    logic          pgm_fire;
    logic          arr_ce;
    logic          unused_ok;

    assign unused_ok = ^{m_ram_raddr[1:0], m_ram_waddr[1:0]};

    // With a one-cycle read the array is addressed straight from the host.
    assign arr_addr = (state == ST_IDLE) ? word_idx(m_ram_raddr) : lat_idx;
    assign rd_issue = (T_RD == 1)
                    ? (state == ST_IDLE && !m_ram_wen && m_ram_ren)
                    : (state == ST_READ && cnt == RD_PRE);
    assign pgm_fire = !resetn && !lat_oor
                    && state == ST_PROG && cnt == PG_LAST;

`ifdef OTP_PGM_VERIFY_EN
    assign vf_issue = state == ST_PROG && cnt == PG_LAST;
`else
    assign vf_issue = 1'b0;
    assign m_ram_wfail = 1'b0;
`endif

    assign arr_ce = !resetn && (rd_issue || vf_issue);

    otp_cell_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk  (clk),
        .ce   (arr_ce),
        .addr (arr_addr),
        .dout (arr_dout),
        .pgm  (pgm_fire),
        .din  (lat_data)
    );

    always_ff @(posedge clk) begin
        if (resetn) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            lat_idx      <= '0;
            lat_oor      <= 1'b0;
            lat_data     <= '0;
            m_ram_rdata  <= '0;
            m_ram_rvalid <= 1'b0;
            m_ram_wdone  <= 1'b0;
            m_ram_busy   <= 1'b0;
`ifdef OTP_PGM_VERIFY_EN
            m_ram_wfail  <= 1'b0;
`endif
        end else begin
            m_ram_rvalid <= 1'b0;
            m_ram_wdone  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (m_ram_wen) begin
                        lat_idx    <= word_idx(m_ram_waddr);
                        lat_oor    <= out_of_range(m_ram_waddr);
                        lat_data   <= m_ram_wdata;
                        state      <= ST_PROG;
                        m_ram_busy <= 1'b1;
                    end else if (m_ram_ren) begin
                        lat_idx    <= word_idx(m_ram_raddr);
                        lat_oor    <= out_of_range(m_ram_raddr);
                        state      <= ST_READ;
                        m_ram_busy <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (cnt == RD_LAST) begin
                        m_ram_rdata  <= lat_oor ? '0 : arr_dout;
                        m_ram_rvalid <= 1'b1;
                        m_ram_busy   <= 1'b0;
                        state        <= ST_IDLE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PROG: begin
                    if (cnt == PG_LAST) begin
                        cnt <= '0;
`ifdef OTP_PGM_VERIFY_EN
                        state <= ST_VERIFY;
`else
                        state       <= ST_IDLE;
                        m_ram_wdone <= 1'b1;
                        m_ram_busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef OTP_PGM_VERIFY_EN
                ST_VERIFY: begin
                    m_ram_wfail <= lat_oor
                                || ((arr_dout & lat_data) != lat_data);
                    m_ram_wdone <= 1'b1;
                    m_ram_busy  <= 1'b0;
                    state       <= ST_IDLE;
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    m_ram_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otp_top.sv
// Scoreboard bench for otp_top: randomized host traffic against a
// word-array reference model, plus the directed reset/abort cases.
module tb_otp_top;

    localparam int DEPTH = 256;
    localparam int T_RD  = 4;
    localparam int T_PGM = 16;
`ifdef OTP_PGM_VERIFY_EN
    localparam int PG_LAT = T_PGM + 1;
`else
    localparam int PG_LAT = T_PGM;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        m_ram_ren;
    logic [31:0] m_ram_raddr;
    logic        m_ram_wen;
    logic [31:0] m_ram_waddr;
    logic [31:0] m_ram_wdata;
    logic [31:0] m_ram_rdata;
    logic        m_ram_rvalid;
    logic        m_ram_wdone;
    logic        m_ram_wfail;
    logic        m_ram_busy;

    otp_top #(
        .DEPTH (DEPTH),
        .T_RD  (T_RD),
        .T_PGM (T_PGM)
    ) u_top (
        .clk          (clk),
        .resetn       (resetn),
        .m_ram_ren    (m_ram_ren),
        .m_ram_raddr  (m_ram_raddr),
        .m_ram_wen    (m_ram_wen),
        .m_ram_waddr  (m_ram_waddr),
        .m_ram_wdata  (m_ram_wdata),
        .m_ram_rdata  (m_ram_rdata),
        .m_ram_rvalid (m_ram_rvalid),
        .m_ram_wdone  (m_ram_wdone),
        .m_ram_wfail  (m_ram_wfail),
        .m_ram_busy   (m_ram_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          prog;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_oor(input logic [31:0] a);
        return (a >> 2) >= DEPTH;
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic push_read(input logic [31:0] a);
        exp_t e;
        e.prog = 1'b0;
        e.cyc  = cyc + T_RD;
        e.data = addr_oor(a) ? 32'h0 : model[addr_idx(a)];
        q.push_back(e);
    endtask

    task automatic push_prog(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.prog = 1'b1;
        e.cyc  = cyc + PG_LAT;
`ifdef OTP_PGM_VERIFY_EN
        e.data = {31'd0, addr_oor(a)};
`else
        e.data = 32'h0;
`endif
        if (!addr_oor(a)) model[addr_idx(a)] = model[addr_idx(a)] | d;
        q.push_back(e);
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (m_ram_rvalid) begin
            if (q.size() == 0) begin
                check(1'b0, "unexpected rvalid", 32'h1, 32'h0);
            end else begin
                e = q.pop_front();
                check(!e.prog, "rvalid order", 32'h1, {31'd0, !e.prog});
                check(e.cyc == cyc, "read latency", cyc, e.cyc);
                check(m_ram_rdata === e.data, "rdata", m_ram_rdata, e.data);
            end
        end
        if (m_ram_wdone) begin
            if (q.size() == 0) begin
                check(1'b0, "unexpected wdone", 32'h1, 32'h0);
            end else begin
                e = q.pop_front();
                check(e.prog, "wdone order", 32'h1, {31'd0, e.prog});
                check(e.cyc == cyc, "program latency", cyc, e.cyc);
                check(m_ram_wfail === e.data[0], "wfail",
                      {31'd0, m_ram_wfail}, e.data);
            end
        end
    end

    task automatic wait_accept(output bit ok);
        bit pb;
        pb = m_ram_busy;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (m_ram_busy && !pb) ok = 1'b1;
            pb = m_ram_busy;
        end
        if (!ok) check(1'b0, "accept timeout", 32'h0, 32'h1);
    endtask

    task automatic request(input bit w, input bit r,
                           input logic [31:0] wa, input logic [31:0] wd,
                           input logic [31:0] ra);
        bit ok;
        m_ram_wen   = w;
        m_ram_waddr = wa;
        m_ram_wdata = wd;
        m_ram_ren   = r;
        m_ram_raddr = ra;
        wait_accept(ok);
        if (ok) begin
            if (w) begin
                push_prog(wa, wd);
                m_ram_wen = 1'b0;
                if (r) begin
                    wait_accept(ok);
                    if (ok) push_read(ra);
                end
            end else begin
                push_read(ra);
            end
        end
        m_ram_wen = 1'b0;
        m_ram_ren = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || m_ram_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(q.size() == 0, "drain timeout", q.size(), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
        if ($urandom_range(0, 7) == 0) a = a | (32'h400 << $urandom_range(0, 21));
        return a;
    endfunction

    initial begin
        bit          ok;
        int          op;
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        resetn      = 1'b1;
        m_ram_ren   = 1'b1;
        m_ram_raddr = 32'h0;
        m_ram_wen   = 1'b0;
        m_ram_waddr = 32'h0;
        m_ram_wdata = 32'h0;

        repeat (3) begin
            @(negedge clk);
            check(m_ram_busy == 1'b0, "reset busy", {31'd0, m_ram_busy}, 32'h0);
            check(m_ram_rvalid == 1'b0, "reset rvalid",
                  {31'd0, m_ram_rvalid}, 32'h0);
            check(m_ram_rdata == 32'h0, "reset rdata", m_ram_rdata, 32'h0);
        end
        resetn = 1'b0;

        // Held read level: one completion every T_RD+1 cycles.
        for (int k = 0; k < 3; k++) begin
            wait_accept(ok);
            if (ok) push_read(32'h0);
        end
        m_ram_ren = 1'b0;

        request(1'b1, 1'b0, 32'h8, 32'h0000_00F0, 32'h0);
        request(1'b1, 1'b0, 32'h8, 32'h0000_000F, 32'h0);
        request(1'b0, 1'b1, 32'h0, 32'h0, 32'h8);
        request(1'b1, 1'b0, 32'h8, 32'h0000_0000, 32'h0);
        request(1'b0, 1'b1, 32'h0, 32'h0, 32'hB);
        request(1'b1, 1'b1, 32'h8, 32'h0000_0100, 32'h8);
        request(1'b1, 1'b0, 32'h400, 32'h0000_0001, 32'h0);
        request(1'b0, 1'b1, 32'h0, 32'h0, 32'h400);
        request(1'b1, 1'b0, 32'h3FC, 32'hA5A5_0000, 32'h0);
        request(1'b0, 1'b1, 32'h0, 32'h0, 32'h3FC);

        // Abort a program with reset part-way through the pulse.
        wait_idle();
        m_ram_wen   = 1'b1;
        m_ram_waddr = 32'h4;
        m_ram_wdata = 32'hFFFF_FFFF;
        wait_accept(ok);
        m_ram_wen = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check(m_ram_busy == 1'b0, "abort busy", {31'd0, m_ram_busy}, 32'h0);
        check(m_ram_rdata == 32'h0, "abort rdata", m_ram_rdata, 32'h0);
        resetn = 1'b0;
        request(1'b0, 1'b1, 32'h0, 32'h0, 32'h4);

        for (int k = 0; k < 40; k++) begin
            op = $urandom_range(0, 2);
            a  = rand_addr();
            request(op != 0, op != 1, a, $urandom & $urandom, rand_addr());
        end

        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

endmodule

// File: doc/otp_top.md
Name: otp_top

Overview:
- Top-level of the OTP PROM cell-logic simulation model: a host-side RAM-style request interface in front of a one-time-programmable word array with fixed read-access and program-pulse latencies.
- A controller ("agent") FSM sequences read and program operations onto a behavioural cell-array sub-module.
- Bits may only be programmed 0->1; they can never be erased.
- Instantiated as u_top in the system bench. The m_ram_* nets are exposed as ports so they can be driven or forced by hierarchical name.

Parameters:
- DEPTH, 256: number of 32-bit words in the array; power of two, at least 2.
- T_RD, 4: read access latency in cycles; at least 1.
- T_PGM, 16: program pulse length in cycles; at least 1.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- resetn  in  1  reset: one clock; reset is synchronous and active-high. resetn=1 is reset asserted, despite the codebase name.
- m_ram_ren  in  1  read request, level.
- m_ram_raddr  in  32  read byte address.
- m_ram_wen  in  1  program request, level.
- m_ram_waddr  in  32  program byte address.
- m_ram_wdata  in  32  bits to program; a 1 sets the bit.
- m_ram_rdata  out  32  read data, valid only while m_ram_rvalid=1.
- m_ram_rvalid  out  1  one-cycle read-complete pulse.
- m_ram_wdone  out  1  one-cycle program-complete pulse.
- m_ram_wfail  out  1  program failure flag; qualified by m_ram_wdone.
- m_ram_busy  out  1  FSM not in IDLE.

Behaviour:
- Addressing: word index = addr[log2(DEPTH)+1:2]; addr[1:0] ignored. Index >= DEPTH, i.e. any set bit in addr[31:log2(DEPTH)+2], is out-of-range.
- Array contents:
  - All zero at time zero.
  - Not affected by reset (non-volatile).
  - Program does word <= word | wdata.
- FSM states: IDLE, READ, PROG, VERIFY (VERIFY exists only with the optional feature).
  - IDLE: requests are sampled only here. If wen=1, latch waddr and wdata, go to PROG; wen has priority over ren. Else if ren=1, latch raddr, go to READ.
  - READ: counts T_RD cycles. On the edge ending the last cycle: rdata <= array[idx] (0 if out-of-range), rvalid <= 1, go to IDLE.
  - PROG: counts T_PGM cycles. The array is updated only on the edge ending the last cycle (out-of-range: no write). Then either go to IDLE with wdone <= 1, or go to VERIFY when the feature is enabled.
- Timing: a request accepted at edge N gives rvalid/wdone high in the cycle after edge N+T_RD (or N+T_PGM). A held request is re-accepted at edge N+T_RD+1, so the read period is T_RD+1 cycles.
- rvalid and wdone are single-cycle pulses.
- rdata holds its last value after rvalid falls.
- busy = (state != IDLE), registered.
- Requests that arrive while busy are neither queued nor acknowledged; the host must hold the level until it is accepted.
- Reset (resetn=1 at an edge):
  - state <= IDLE, counters <= 0.
  - rdata <= 0, rvalid <= 0, wdone <= 0, wfail <= 0, busy <= 0.
  - An in-flight program is aborted and the target word is unchanged.
- While reset is held, no request is accepted.

Optional Feature:
- Macro: OTP_PGM_VERIFY_EN.
- Enabled:
  - After PROG, one VERIFY cycle reads the target word.
  - wfail <= 1 if (word & wdata) != wdata, or if the address is out-of-range.
  - wdone pulses on exit from VERIFY.
  - Program latency is T_PGM+1.
- Disabled:
  - No VERIFY state.
  - wfail is constant 0.

Decomposition:
- Package otp_pkg holds: FSM state encoding (IDLE=0, READ=1, PROG=2, VERIFY=3), the data width constant (32), and the function computing word-index width from DEPTH.
- One sub-module, otp_cell_array, holds the array and has:
  - synchronous read port: ce, addr, dout;
  - program port: pgm, addr, din, which ORs din into the word;
  - an initial block that zeroes the array.
- The controller FSM lives in otp_top.

Test Plan:
- Reset held at 1 for 3 edges with ren=1 -> busy=0, rvalid=0, rdata=0 throughout; no request accepted.
- Release reset, ren=1 continuously, raddr=0 -> rvalid pulses every 5 cycles (T_RD=4), rdata=0x00000000.
- Program waddr=0x8, wdata=0x000000F0, then wdata=0x0000000F -> each wdone after 16 cycles; read 0x8 returns 0x000000FF.
- Program 0x8 with 0x00000000 after the above -> word still 0x000000FF (no erase); wen and ren high together -> program served first.
- Assert reset at PROG cycle 10 of a program of 0xFFFFFFFF to 0x4 -> busy=0 next cycle; subsequent read of 0x4 returns 0.
- With OTP_PGM_VERIFY_EN: program out-of-range 0x400 -> wdone with wfail=1 at cycle 17; an in-range program gives wfail=0.
